// File: rtl/axi4s_vid_out_pkg.sv
// Shared FSM state type and frame-geometry helpers for the AXI4-Stream to native video bridge.
package axi4s_vid_out_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2
  } state_t;

  function automatic int sum4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  // Totals for the default 720p geometry; other geometries derive theirs with sum4().
  localparam int H_TOT = sum4(1280, 110, 40, 220);
  localparam int V_TOT = sum4(720, 5, 5, 20);

endpackage

// File: rtl/axi4s_vid_out_tgen_if.sv
// AXI4-Stream video bus: tuser marks start of frame, tlast marks end of line.
interface axi4s_vid_out_tgen_if #(
  parameter int C_TDATA_WIDTH = 32
) ();
  logic [C_TDATA_WIDTH-1:0] tdata;
  logic                     tvalid;
  logic                     tready;
  logic                     tuser;
  logic                     tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/vid_out_timing_gen.sv
// Free-running raster counters with registered active, blank and sync outputs.
module vid_out_timing_gen
  import axi4s_vid_out_pkg::*;
#(
  parameter int C_CNT_WIDTH = 12,
  parameter int C_H_ACTIVE  = 1280,
  parameter int C_H_FP      = 110,
  parameter int C_H_SYNC    = 40,
  parameter int C_H_BP      = 220,
  parameter int C_V_ACTIVE  = 720,
  parameter int C_V_FP      = 5,
  parameter int C_V_SYNC    = 5,
  parameter int C_V_BP      = 20,
  parameter bit C_HSYNC_POL = 1'b1,
  parameter bit C_VSYNC_POL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  output logic [C_CNT_WIDTH-1:0] h,
  output logic [C_CNT_WIDTH-1:0] v,
  output logic                   active_c,
  output logic                   active,
  output logic                   hblank,
  output logic                   vblank,
  output logic                   hsync,
  output logic                   vsync
);

  localparam int H_TOTAL = sum4(C_H_ACTIVE, C_H_FP, C_H_SYNC, C_H_BP);
  localparam int V_TOTAL = sum4(C_V_ACTIVE, C_V_FP, C_V_SYNC, C_V_BP);

  localparam logic [C_CNT_WIDTH-1:0] ONE      = C_CNT_WIDTH'(1);
  localparam logic [C_CNT_WIDTH-1:0] H_LAST   = C_CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [C_CNT_WIDTH-1:0] V_LAST   = C_CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [C_CNT_WIDTH-1:0] H_ACT    = C_CNT_WIDTH'(C_H_ACTIVE);
  localparam logic [C_CNT_WIDTH-1:0] V_ACT    = C_CNT_WIDTH'(C_V_ACTIVE);
  localparam logic [C_CNT_WIDTH-1:0] H_SYNC_S = C_CNT_WIDTH'(C_H_ACTIVE + C_H_FP);
  localparam logic [C_CNT_WIDTH-1:0] H_SYNC_E = C_CNT_WIDTH'(C_H_ACTIVE + C_H_FP + C_H_SYNC);
  localparam logic [C_CNT_WIDTH-1:0] V_SYNC_S = C_CNT_WIDTH'(C_V_ACTIVE + C_V_FP);
  localparam logic [C_CNT_WIDTH-1:0] V_SYNC_E = C_CNT_WIDTH'(C_V_ACTIVE + C_V_FP + C_V_SYNC);

  logic h_wrap, v_wrap, hblank_c, vblank_c, hsync_c, vsync_c;

  assign h_wrap   = (h == H_LAST);
  assign v_wrap   = (v == V_LAST);
  assign hblank_c = (h >= H_ACT);
  assign vblank_c = (v >= V_ACT);
  assign active_c = ~hblank_c & ~vblank_c;
  assign hsync_c  = (h >= H_SYNC_S) && (h < H_SYNC_E);
  assign vsync_c  = (v >= V_SYNC_S) && (v < V_SYNC_E);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h      <= '0;
      v      <= '0;
      active <= 1'b0;
      hblank <= 1'b0;
      vblank <= 1'b0;
      hsync  <= ~C_HSYNC_POL;
      vsync  <= ~C_VSYNC_POL;
    end else if (ce) begin
      h <= h_wrap ? '0 : h + ONE;
      if (h_wrap) begin
        v <= v_wrap ? '0 : v + ONE;
      end
      // Outputs describe the counter value of the cycle just ended.
      active <= active_c;
      hblank <= hblank_c;
      vblank <= vblank_c;
      hsync  <= hsync_c ? C_HSYNC_POL : ~C_HSYNC_POL;
      vsync  <= vsync_c ? C_VSYNC_POL : ~C_VSYNC_POL;
    end
  end

endmodule

// File: rtl/axi4s_vid_out_tgen.sv
// AXI4-Stream video to native parallel video, aligning stream frames to the generated raster.
module axi4s_vid_out_tgen
  import axi4s_vid_out_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_CNT_WIDTH          = 12,
  parameter int C_H_ACTIVE           = 1280,
  parameter int C_H_FP               = 110,
  parameter int C_H_SYNC             = 40,
  parameter int C_H_BP               = 220,
  parameter int C_V_ACTIVE           = 720,
  parameter int C_V_FP               = 5,
  parameter int C_V_SYNC             = 5,
  parameter int C_V_BP               = 20,
  parameter bit C_HSYNC_POL          = 1'b1,
  parameter bit C_VSYNC_POL          = 1'b1
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            aclken,
  input  logic                            enable,
  axi4s_vid_out_tgen_if.slave             s_axis_video,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] vid_data,
  output logic                            vid_active_video,
  output logic                            vid_hblank,
  output logic                            vid_vblank,
  output logic                            vid_hsync,
  output logic                            vid_vsync,
  output logic                            locked,
  output logic                            underflow,
  output logic                            line_err
);

  localparam logic [C_CNT_WIDTH-1:0] H_LAST_ACT = C_CNT_WIDTH'(C_H_ACTIVE - 1);

  logic [C_CNT_WIDTH-1:0]          h, v;
  logic                            active_c, origin, last_col, tready_c;
  logic [C_M_AXIS_TDATA_WIDTH-1:0] data_n;
  logic                            underflow_n, line_err_n;
  state_t                          state, state_n;

  vid_out_timing_gen #(
    .C_CNT_WIDTH (C_CNT_WIDTH),
    .C_H_ACTIVE  (C_H_ACTIVE),
    .C_H_FP      (C_H_FP),
    .C_H_SYNC    (C_H_SYNC),
    .C_H_BP      (C_H_BP),
    .C_V_ACTIVE  (C_V_ACTIVE),
    .C_V_FP      (C_V_FP),
    .C_V_SYNC    (C_V_SYNC),
    .C_V_BP      (C_V_BP),
    .C_HSYNC_POL (C_HSYNC_POL),
    .C_VSYNC_POL (C_VSYNC_POL)
  ) u_timing (
    .clk      (aclk),
    .rst_n    (aresetn),
    .ce       (aclken),
    .h        (h),
    .v        (v),
    .active_c (active_c),
    .active   (vid_active_video),
    .hblank   (vid_hblank),
    .vblank   (vid_vblank),
    .hsync    (vid_hsync),
    .vsync    (vid_vsync)
  );

  assign origin   = (h == '0) && (v == '0);
  assign last_col = (h == H_LAST_ACT);

  // Ready never rises while the block is frozen or held in reset.
  assign s_axis_video.tready = tready_c & aclken & aresetn;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    tready_c    = 1'b0;
    data_n      = '0;
    underflow_n = 1'b0;
    line_err_n  = 1'b0;
    if (!enable) begin
      state_n = WAIT_SOF;
    end else begin
      unique case (state)
        WAIT_SOF: begin
          tready_c = ~s_axis_video.tuser;
          if (s_axis_video.tvalid && s_axis_video.tuser) state_n = ARMED;
        end
        ARMED, RUN: begin
          // An armed SOF beat is consumed exactly like a running pixel at the frame origin.
          if (state == RUN || origin) begin
            tready_c = active_c & ~(s_axis_video.tuser & ~origin);
            if (active_c) begin
              if (!s_axis_video.tvalid) begin
                underflow_n = 1'b1;
                state_n     = WAIT_SOF;
              end else if (s_axis_video.tuser && !origin) begin
                line_err_n = 1'b1;
                state_n    = ARMED;
              end else begin
                data_n  = s_axis_video.tdata;
                state_n = RUN;
                if (s_axis_video.tlast != last_col) begin
                  line_err_n = 1'b1;
                  state_n    = WAIT_SOF;
                end
              end
            end
          end
        end
        default: state_n = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= WAIT_SOF;
      vid_data  <= '0;
      locked    <= 1'b0;
      underflow <= 1'b0;
      line_err  <= 1'b0;
    end else if (aclken) begin
      state     <= state_n;
      vid_data  <= data_n;
      locked    <= (state_n == RUN);
      underflow <= underflow_n;
      line_err  <= line_err_n;
    end
  end

endmodule

// File: tb/tb_axi4s_vid_out_tgen.sv
// Directed bench for axi4s_vid_out_tgen on a 14x7 raster (H 8/2/2/2, V 4/1/1/1).
module tb_axi4s_vid_out_tgen;

  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn, aclken, enable;
  logic [DW-1:0] vid_data;
  logic          vid_active_video, vid_hblank, vid_vblank, vid_hsync, vid_vsync;
  logic          locked, underflow, line_err;
  logic [7:0]    ctrl;

  beat_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_acc   = 0;
  int    cut_pix, cut_kind, gap_pos, line_off;
  bit    half;

  axi4s_vid_out_tgen_if #(.C_TDATA_WIDTH(DW)) s_if ();

  axi4s_vid_out_tgen #(
    .C_M_AXIS_TDATA_WIDTH (DW),
    .C_CNT_WIDTH          (12),
    .C_H_ACTIVE           (8),
    .C_H_FP               (2),
    .C_H_SYNC             (2),
    .C_H_BP               (2),
    .C_V_ACTIVE           (4),
    .C_V_FP               (1),
    .C_V_SYNC             (1),
    .C_V_BP               (1),
    .C_HSYNC_POL          (1'b1),
    .C_VSYNC_POL          (1'b1)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .aclken           (aclken),
    .enable           (enable),
    .s_axis_video     (s_if),
    .vid_data         (vid_data),
    .vid_active_video (vid_active_video),
    .vid_hblank       (vid_hblank),
    .vid_vblank       (vid_vblank),
    .vid_hsync        (vid_hsync),
    .vid_vsync        (vid_vsync),
    .locked           (locked),
    .underflow        (underflow),
    .line_err         (line_err)
  );

  always #5 aclk = ~aclk;

  assign ctrl = {vid_active_video, vid_hblank, vid_vblank, vid_hsync, vid_vsync,
                 locked, underflow, line_err};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // kind 1: extra tlast at line 2 column 5; kind 2: stray tuser at line 2 column 0.
  task automatic push_frame(input int kind);
    beat_t b;
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 8; c++) begin
        b.d = DW'(16 * l + c);
        b.u = (l == 0 && c == 0) || (kind == 2 && l == 2 && c == 0);
        b.l = (c == 7) || (kind == 1 && l == 2 && c == 5);
        q.push_back(b);
      end
    end
  endtask

  task automatic drive(input bit gap);
    s_if.tvalid = (q.size() > 0) && !gap;
    if (q.size() > 0) begin
      s_if.tdata = q[0].d;
      s_if.tuser = q[0].u;
      s_if.tlast = q[0].l;
    end else begin
      s_if.tdata = '0;
      s_if.tuser = 1'b0;
      s_if.tlast = 1'b0;
    end
  endtask

  task automatic clock_beat();
    bit acc;
    @(negedge aclk);
    acc = s_if.tvalid && s_if.tready;
    @(posedge aclk);
    #1;
    if (acc) begin
      void'(q.pop_front());
      n_acc++;
    end
  endtask

  // Expected outputs for raster position p of the current frame, from the scenario settings.
  task automatic check_pos(input string tag, input int p);
    int            hh, vv, k, pcut;
    bit            act;
    logic [DW-1:0] d_exp;
    logic [7:0]    c_exp;
    hh    = p % 14;
    vv    = p / 14;
    act   = (hh < 8) && (vv < 4);
    k     = vv * 8 + hh;
    pcut  = (cut_pix >= 32) ? 98 : (cut_pix / 8) * 14 + cut_pix % 8;
    d_exp = (act && (k < cut_pix || (k == cut_pix && cut_kind == 2)))
            ? DW'(16 * ((vv + line_off) % 4) + hh) : '0;
    c_exp = {act, hh >= 8, vv >= 4, (hh >= 10) && (hh < 12), vv == 5,
             p < pcut, (cut_kind == 1) && (p == pcut), (cut_kind >= 2) && (p == pcut)};
    check($sformatf("%s p%0d data", tag, p), vid_data, d_exp);
    check($sformatf("%s p%0d ctrl", tag, p), DW'(ctrl), DW'(c_exp));
  endtask

  task automatic run_frame(input string tag, input int n_pos);
    for (int p = 0; p < n_pos; p++) begin
      aclken = 1'b1;
      drive(p == gap_pos);
      clock_beat();
      check_pos(tag, p);
      if (half) begin
        aclken = 1'b0;
        drive(p == gap_pos);
        @(negedge aclk);
        check($sformatf("%s p%0d stall tready", tag, p), DW'(s_if.tready), '0);
        @(posedge aclk);
        #1;
        check_pos({tag, " hold"}, p);
      end
    end
    aclken = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " data"}, vid_data, '0);
    check({tag, " ctrl"}, DW'(ctrl), '0);
    check({tag, " tready"}, DW'(s_if.tready), '0);
  endtask

  initial begin
    aresetn     = 1'b0;
    aclken      = 1'b1;
    enable      = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    cut_pix     = 0;
    cut_kind    = 0;
    gap_pos     = -1;
    line_off    = 0;
    half        = 1'b0;

    for (int i = 0; i < 5; i++) q.push_back('{d: DW'(32'hdead_0000 + i), u: 1'b0, l: 1'b0});
    push_frame(0);  // A: clean
    push_frame(0);  // B: underflow
    push_frame(0);  // C: relock
    push_frame(1);  // D: early tlast
    push_frame(2);  // E: stray tuser
    push_frame(0);  // F: realigned
    push_frame(0);  // G: half rate, reset mid-frame
    push_frame(0);  // H: relock after reset

    // Junk at the head of the stream must not be drained while reset holds ready low.
    drive(1'b0);
    repeat (3) @(posedge aclk);
    #1;
    check_reset("reset");
    #1 aresetn = 1'b1;

    n_acc = 0;
    run_frame("sync", 98);
    check("junk drained", DW'(n_acc), DW'(5));

    cut_pix = 32; cut_kind = 0;
    run_frame("clean", 98);

    cut_pix = 11; cut_kind = 1; gap_pos = 17;
    run_frame("uflow", 98);
    gap_pos = -1;

    cut_pix = 32; cut_kind = 0;
    run_frame("relock", 98);

    cut_pix = 21; cut_kind = 2;
    run_frame("tlast", 98);

    cut_pix = 16; cut_kind = 3;
    run_frame("stray", 98);

    line_off = 2;
    run_frame("resume", 98);
    line_off = 0;

    cut_pix = 32; cut_kind = 0;
    run_frame("realign", 98);

    half = 1'b1;
    run_frame("half", 44);
    half = 1'b0;

    // Mid-frame reset lands between clock edges; outputs must clear without waiting for one.
    #2 aresetn = 1'b0;
    #1;
    check_reset("async reset");
    repeat (2) @(posedge aclk);
    #2 aresetn = 1'b1;

    n_acc    = 0;
    cut_pix  = 0;
    cut_kind = 0;
    run_frame("post reset", 98);
    check("tail drained", DW'(n_acc), DW'(6));

    cut_pix = 32;
    run_frame("relock2", 98);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
